// File: rtl/music_box_mode_arbiter.sv
// Priority arbiter that hands one SDRAM command port and one DAC path to a single mode
// sub-controller at a time, with drain-before-release, button re-arm and a sticky watchdog.
//
// state   | meaning
// IDLE    | no mode running, waiting for any button press
// ACTIVE  | selected mode owns SDRAM port and audio path
// DRAIN   | mode finished, waiting for SDRAM controller to go idle
// RELEASE | waiting for every button to be released
// ERROR   | watchdog fired, held until reset
module music_box_mode_arbiter #(
    parameter int                     NUM_MODES      = 4,
    parameter int                     ADDR_WIDTH     = 25,
    parameter int                     DATA_WIDTH     = 16,
    parameter int                     AUDIO_WIDTH    = 8,
    parameter logic [AUDIO_WIDTH-1:0] AUDIO_IDLE     = '0,
    parameter int                     TIMEOUT_CYCLES = 0,
    parameter int                     MODE_W         = $clog2(NUM_MODES + 1)
) (
    input  logic                              clock_50Mhz,
    input  logic                              reset_n,
    input  logic [NUM_MODES-1:0]              request_n,
    input  logic [NUM_MODES-1:0]              mode_complete,
    output logic [NUM_MODES-1:0]              mode_enable,
    output logic [MODE_W-1:0]                 active_mode,
    output logic                              error,
    input  logic [NUM_MODES*AUDIO_WIDTH-1:0]  mode_audio,
    output logic [AUDIO_WIDTH-1:0]            audio_out,
    input  logic [NUM_MODES*ADDR_WIDTH-1:0]   mode_sdram_address,
    input  logic [NUM_MODES*DATA_WIDTH-1:0]   mode_sdram_writeData,
    input  logic [NUM_MODES-1:0]              mode_sdram_isWriting,
    input  logic [NUM_MODES-1:0]              mode_sdram_inputValid,
    output logic [ADDR_WIDTH-1:0]             sdram_inputAddress,
    output logic [DATA_WIDTH-1:0]             sdram_writeData,
    output logic                              sdram_isWriting,
    output logic                              sdram_inputValid,
    input  logic                              sdram_isBusy
);

    localparam int SEL_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACTIVE  = 3'd1,
        S_DRAIN   = 3'd2,
        S_RELEASE = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [NUM_MODES-1:0]   enable_q, enable_d;
    logic [MODE_W-1:0]      active_q, active_d;
    logic                   error_q, error_d;
    logic [AUDIO_WIDTH-1:0] audio_q, audio_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [SEL_W-1:0]       pick;
    logic [NUM_MODES-1:0]   pick_onehot;

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            enable_q <= '0;
            active_q <= '0;
            error_q  <= 1'b0;
            audio_q  <= AUDIO_IDLE;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            active_q <= active_d;
            error_q  <= error_d;
            audio_q  <= audio_d;
            cnt_q    <= cnt_d;
        end
    end

    // Ascending scan so the highest-index pressed button is the last one written.
    always_comb begin
        pick        = '0;
        pick_onehot = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (!request_n[i]) begin
                pick           = SEL_W'(i);
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        enable_d = enable_q;
        active_d = active_q;
        error_d  = error_q;
        cnt_d    = cnt_q;
        audio_d  = (state_q == S_ACTIVE) ? mode_audio[sel_q*AUDIO_WIDTH +: AUDIO_WIDTH]
                                         : AUDIO_IDLE;
        case (state_q)
            S_IDLE: begin
                if (!(&request_n)) begin
                    state_d  = S_ACTIVE;
                    sel_d    = pick;
                    enable_d = pick_onehot;
                    active_d = MODE_W'(pick) + MODE_W'(1);
                    cnt_d    = '0;
                end
            end
            S_ACTIVE: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (mode_complete[sel_q]) begin
                    state_d  = S_DRAIN;
                    enable_d = '0;
                    active_d = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d  = S_ERROR;
                    enable_d = '0;
                    active_d = '0;
                    error_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!sdram_isBusy) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (&request_n) state_d = S_IDLE;
            end
            S_ERROR: begin
                enable_d = '0;
                active_d = '0;
                error_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Zero-latency command path; anything other than ACTIVE presents an all-zero command.
    always_comb begin
        sdram_inputAddress = '0;
        sdram_writeData    = '0;
        sdram_isWriting    = 1'b0;
        sdram_inputValid   = 1'b0;
        if (state_q == S_ACTIVE) begin
            sdram_inputAddress = mode_sdram_address[sel_q*ADDR_WIDTH +: ADDR_WIDTH];
            sdram_writeData    = mode_sdram_writeData[sel_q*DATA_WIDTH +: DATA_WIDTH];
            sdram_isWriting    = mode_sdram_isWriting[sel_q];
            sdram_inputValid   = mode_sdram_inputValid[sel_q];
        end
    end

    assign mode_enable = enable_q;
    assign active_mode = active_q;
    assign error       = error_q;
    assign audio_out   = audio_q;

endmodule

// File: tb/tb_music_box_mode_arbiter.sv
// Randomized scoreboard bench: a cycle-level reference of the arbitration rules queues the
// expected outputs each cycle and a negedge monitor compares the DUT against them.
module tb_music_box_mode_arbiter;

    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int XW = 8;
    localparam int TO = 100;
    localparam int MW = 3;
    localparam logic [XW-1:0] AIDLE = 8'h5A;

    localparam int P_IDLE = 0, P_ACT = 1, P_DRAIN = 2, P_REL = 3, P_ERR = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    request_n, mode_complete, mode_enable;
    logic [MW-1:0]   active_mode;
    logic            error;
    logic [N*XW-1:0] mode_audio;
    logic [XW-1:0]   audio_out;
    logic [N*AW-1:0] mode_sdram_address;
    logic [N*DW-1:0] mode_sdram_writeData;
    logic [N-1:0]    mode_sdram_isWriting, mode_sdram_inputValid;
    logic [AW-1:0]   sdram_inputAddress;
    logic [DW-1:0]   sdram_writeData;
    logic            sdram_isWriting, sdram_inputValid, sdram_isBusy;

    music_box_mode_arbiter #(
        .NUM_MODES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AUDIO_WIDTH(XW),
        .AUDIO_IDLE(AIDLE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock_50Mhz(clk), .reset_n(reset_n), .request_n(request_n),
        .mode_complete(mode_complete), .mode_enable(mode_enable),
        .active_mode(active_mode), .error(error), .mode_audio(mode_audio),
        .audio_out(audio_out), .mode_sdram_address(mode_sdram_address),
        .mode_sdram_writeData(mode_sdram_writeData),
        .mode_sdram_isWriting(mode_sdram_isWriting),
        .mode_sdram_inputValid(mode_sdram_inputValid),
        .sdram_inputAddress(sdram_inputAddress), .sdram_writeData(sdram_writeData),
        .sdram_isWriting(sdram_isWriting), .sdram_inputValid(sdram_inputValid),
        .sdram_isBusy(sdram_isBusy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  en;
        logic [MW-1:0] am;
        logic          err;
        logic [XW-1:0] aud;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          wr;
        logic          v;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    int            m_phase, m_mode, m_start, cyc;
    logic [XW-1:0] m_aud;

    int comp_pct     = 15;
    int req_idle_pct = 50;
    bit force_valid  = 1'b0;

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_mode  = 0;
        m_aud   = AIDLE;
    endfunction

    // Applies one rising edge to the reference using the inputs the DUT just sampled.
    function automatic void model_edge();
        logic [XW-1:0] aud_n;
        cyc++;
        if (!reset_n) begin
            model_reset();
            return;
        end
        aud_n = (m_phase == P_ACT) ? mode_audio[m_mode*XW +: XW] : AIDLE;
        case (m_phase)
            P_IDLE: if (request_n != '1) begin
                for (int i = 0; i < N; i++) if (!request_n[i]) m_mode = i;
                m_phase = P_ACT;
                m_start = cyc;
            end
            P_ACT: begin
                if (mode_complete[m_mode]) m_phase = P_DRAIN;
                else if (cyc - m_start == TO) m_phase = P_ERR;
            end
            P_DRAIN: if (!sdram_isBusy) m_phase = P_REL;
            P_REL:   if (&request_n) m_phase = P_IDLE;
            default: ;
        endcase
        m_aud = aud_n;
    endfunction

    function automatic void push_expect();
        exp_t e;
        bit   act;
        act   = (m_phase == P_ACT) && reset_n;
        e     = '0;
        e.aud = m_aud;
        e.err = (m_phase == P_ERR) && reset_n;
        if (act) begin
            e.en[m_mode] = 1'b1;
            e.am   = MW'(m_mode + 1);
            e.addr = mode_sdram_address[m_mode*AW +: AW];
            e.wd   = mode_sdram_writeData[m_mode*DW +: DW];
            e.wr   = mode_sdram_isWriting[m_mode];
            e.v    = mode_sdram_inputValid[m_mode];
        end
        exp_q.push_back(e);
    endfunction

    task automatic drive_random();
        request_n = ($urandom_range(99) < req_idle_pct) ? '1 : N'($urandom);
        mode_complete = '0;
        for (int i = 0; i < N; i++)
            if ($urandom_range(99) < comp_pct) mode_complete[i] = 1'b1;
        for (int i = 0; i < N; i++) begin
            mode_audio[i*XW +: XW]           = XW'($urandom);
            mode_sdram_address[i*AW +: AW]   = AW'($urandom);
            mode_sdram_writeData[i*DW +: DW] = DW'($urandom);
        end
        mode_sdram_isWriting  = N'($urandom);
        mode_sdram_inputValid = force_valid ? '1 : N'($urandom);
        sdram_isBusy          = 1'($urandom_range(1));
    endtask

    task automatic run_cycle(input logic rst_val);
        @(posedge clk);
        #1;
        model_edge();
        drive_random();
        reset_n = rst_val;
        if (!reset_n) model_reset();
        push_expect();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctrl", 64'({mode_enable, active_mode, error}), 64'({e.en, e.am, e.err}));
            check("audio", 64'(audio_out), 64'(e.aud));
            check("sdram", 64'({sdram_inputAddress, sdram_writeData, sdram_isWriting, sdram_inputValid}),
                  64'({e.addr, e.wd, e.wr, e.v}));
        end
    end

    initial begin
        bit reached;
        reset_n               = 1'b0;
        request_n             = '1;
        mode_complete         = '0;
        mode_audio            = '0;
        mode_sdram_address    = '0;
        mode_sdram_writeData  = '0;
        mode_sdram_isWriting  = '0;
        mode_sdram_inputValid = '0;
        sdram_isBusy          = 1'b0;
        cyc     = 0;
        m_start = 0;
        model_reset();

        run_cycle(1'b0);
        run_cycle(1'b0);

        // Mixed traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(299) == 0) begin
                run_cycle(1'b0);
                run_cycle(1'b0);
            end
            run_cycle(1'b1);
        end

        // Watchdog: no completions at all, error must stick through further presses
        comp_pct = 0;
        run_cycle(1'b0);
        for (int c = 0; c < 150; c++) run_cycle(1'b1);
        #2;
        check("watchdog_error", 64'(error), 64'(m_phase == P_ERR));
        check("watchdog_phase", 64'(m_phase), 64'(P_ERR));
        run_cycle(1'b0);
        run_cycle(1'b1);

        // Asynchronous reset while a valid command is being forwarded
        force_valid  = 1'b1;
        req_idle_pct = 20;
        reached      = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            run_cycle(1'b1);
            if (m_phase == P_ACT) reached = 1'b1;
        end
        check("reach_active", 64'(reached), 64'(1));
        run_cycle(1'b1);
        @(posedge clk);
        #1;
        model_edge();
        drive_random();
        #1;
        check("valid_before_reset", 64'(sdram_inputValid), 64'(m_phase == P_ACT));
        reset_n = 1'b0;
        model_reset();
        #1;
        check("valid_on_reset", 64'(sdram_inputValid), 64'(0));
        check("audio_on_reset", 64'(audio_out), 64'(AIDLE));
        check("enable_on_reset", 64'({mode_enable, active_mode}), 64'(0));
        push_expect();
        run_cycle(1'b0);
        force_valid  = 1'b0;
        req_idle_pct = 50;
        comp_pct     = 15;
        for (int c = 0; c < 200; c++) run_cycle(1'b1);

        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
